// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and size helpers for the RSA stream core
// Purpose: FSM state encoding and byte/counter width derivation used by
//          rsa_stream_core and its modular multiplier.
// Ports:   none (package)
package rsa_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_KEY,
    ST_LD_MOD,
    ST_LD_TXT,
    ST_CHECK,
    ST_REDUCE,
    ST_SQR,
    ST_MUL,
    ST_SEND,
    ST_FIN
  } state_t;

  // Bytes per operand.
  function automatic int nb_of(input int word_w);
    return word_w / 8;
  endfunction

  // Width of a counter that must hold 0..NB.
  function automatic int byte_cnt_w(input int word_w);
    return $clog2(word_w / 8 + 1);
  endfunction

endpackage

// File: rtl/rsa_stream_core_mod_mul.sv
// rtl/rsa_stream_core_mod_mul.sv - bit-serial Blakley modular multiplier
// Purpose: p = a*b mod m, one bit of a per cycle, MSB first.
// Ports:   clk, reset (async active-low), start (load operands),
//          a/b/m (operands, b < m), done (one-cycle pulse), p (result,
//          valid while done is high and until the next start).
module mod_mul_serial #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] m,
  output logic              done,
  output logic [WORD_W-1:0] p
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] a_r;
  logic [WORD_W+1:0] b_r;
  logic [WORD_W+1:0] m_r;
  logic [WORD_W+1:0] p_r;
  logic [CW-1:0]     cnt;
  logic              run;

  logic [WORD_W+1:0] p_dbl;
  logic [WORD_W+1:0] p_s1;
  logic [WORD_W+1:0] p_nxt;

  // P < m and b < m keep 2P+b below 3m, so two conditional subtracts
  // always bring the partial product back under m.
  always_comb begin
    p_dbl = {p_r[WORD_W:0], 1'b0} + (a_r[WORD_W-1] ? b_r : '0);
    p_s1  = (p_dbl >= m_r) ? (p_dbl - m_r) : p_dbl;
    p_nxt = (p_s1 >= m_r) ? (p_s1 - m_r) : p_s1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r  <= '0;
      b_r  <= '0;
      m_r  <= '0;
      p_r  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r <= a;
        b_r <= {2'b00, b};
        m_r <= {2'b00, m};
        p_r <= '0;
        cnt <= CW'(WORD_W);
        run <= 1'b1;
      end else if (run) begin
        p_r <= p_nxt;
        a_r <= {a_r[WORD_W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = p_r[WORD_W-1:0];

endmodule

// File: rtl/rsa_stream_core.sv
// rtl/rsa_stream_core.sv - streaming RSA modular exponentiation core
// Purpose: loads key, modulus and text bytes from the RX FIFO, computes
//          text^key mod modulus by left-to-right square-and-multiply and
//          writes the result bytes to the TX FIFO, MSB first.
// Ports:   clk, reset (async active-low), start/key_reuse (block request),
//          rx_data/rx_empty/rx_rd (RX FIFO), tx_data/tx_full/tx_wr
//          (TX FIFO), busy, done, err_mod, key_valid (status).
module rsa_stream_core
  import rsa_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_reuse,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_rd,
  output logic [7:0] tx_data,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic       busy,
  output logic       done,
  output logic       err_mod,
  output logic       key_valid
);

  localparam int NB  = nb_of(WORD_W);
  localparam int BCW = byte_cnt_w(WORD_W);
  localparam int BIW = $clog2(WORD_W);
  localparam logic [BCW-1:0]    LAST_BYTE = BCW'(NB - 1);
  localparam logic [WORD_W-1:0] ONE       = {{(WORD_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [WORD_W-1:0] key_r, mod_r, txt_r, base_r, acc_init, send_sr;
  logic [BCW-1:0]    byte_cnt;
  logic [BIW-1:0]    bit_idx;
  logic              rd_pend;

  logic              mm_start, mm_done;
  logic [WORD_W-1:0] mm_a, mm_b, mm_p;

  mod_mul_serial #(.WORD_W(WORD_W)) u_mm (
    .clk   (clk),
    .reset (reset),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mod_r),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Each multiply is launched in the cycle its predecessor completes, so
  // every REDUCE/SQR/MUL step occupies exactly WORD_W+1 cycles.
  always_comb begin
    state_d  = state_q;
    rx_rd    = 1'b0;
    tx_wr    = 1'b0;
    mm_start = 1'b0;
    mm_a     = mm_p;
    mm_b     = mm_p;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (key_reuse && key_valid) ? ST_LD_TXT : ST_LD_KEY;
      end
      ST_LD_KEY, ST_LD_MOD, ST_LD_TXT: begin
        rx_rd = !rd_pend && !rx_empty;
        if (rd_pend && byte_cnt == LAST_BYTE) begin
          case (state_q)
            ST_LD_KEY: state_d = ST_LD_MOD;
            ST_LD_MOD: state_d = ST_LD_TXT;
            default:   state_d = ST_CHECK;
          endcase
        end
      end
      ST_CHECK: begin
        if (mod_r == '0) begin
          state_d = ST_SEND;
        end else begin
          mm_start = 1'b1;
          mm_a     = txt_r;
          mm_b     = ONE;
          state_d  = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (mm_done) begin
          mm_start = 1'b1;
          mm_a     = acc_init;
          mm_b     = acc_init;
          state_d  = ST_SQR;
        end
      end
      ST_SQR: begin
        if (mm_done) begin
          if (key_r[bit_idx]) begin
            mm_start = 1'b1;
            mm_b     = base_r;
            state_d  = ST_MUL;
          end else if (bit_idx == '0) begin
            state_d = ST_SEND;
          end else begin
            mm_start = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mm_done) begin
          if (bit_idx == '0) begin
            state_d = ST_SEND;
          end else begin
            mm_start = 1'b1;
            state_d  = ST_SQR;
          end
        end
      end
      ST_SEND: begin
        tx_wr = !tx_full;
        if (!tx_full && byte_cnt == LAST_BYTE) state_d = ST_FIN;
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r     <= '0;
      mod_r     <= '0;
      txt_r     <= '0;
      base_r    <= '0;
      acc_init  <= '0;
      send_sr   <= '0;
      byte_cnt  <= '0;
      bit_idx   <= '0;
      rd_pend   <= 1'b0;
      err_mod   <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      rd_pend <= rx_rd;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_mod  <= 1'b0;
            byte_cnt <= '0;
            if (!(key_reuse && key_valid)) key_valid <= 1'b0;
          end
        end
        ST_LD_KEY, ST_LD_MOD, ST_LD_TXT: begin
          if (rd_pend) begin
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
            case (state_q)
              ST_LD_KEY: key_r <= {key_r[WORD_W-9:0], rx_data};
              ST_LD_MOD: mod_r <= {mod_r[WORD_W-9:0], rx_data};
              default:   txt_r <= {txt_r[WORD_W-9:0], rx_data};
            endcase
            if (state_q == ST_LD_MOD && byte_cnt == LAST_BYTE) key_valid <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (mod_r == '0) begin
            err_mod <= 1'b1;
            send_sr <= '0;
          end else begin
            // x mod 1 is 0 for every x, including x^0.
            acc_init <= (mod_r == ONE) ? '0 : ONE;
            bit_idx  <= BIW'(WORD_W - 1);
          end
        end
        ST_REDUCE: begin
          if (mm_done) base_r <= mm_p;
        end
        ST_SQR: begin
          if (mm_done && !key_r[bit_idx]) begin
            if (bit_idx == '0) send_sr <= mm_p;
            else               bit_idx <= bit_idx - 1'b1;
          end
        end
        ST_MUL: begin
          if (mm_done) begin
            if (bit_idx == '0) send_sr <= mm_p;
            else               bit_idx <= bit_idx - 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_wr) begin
            send_sr  <= {send_sr[WORD_W-9:0], 8'h00};
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data = (state_q == ST_SEND) ? send_sr[WORD_W-1 -: 8] : 8'h00;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done    = (state_q == ST_FIN);

endmodule

// File: doc/rsa_stream_core.md
# rsa_stream_core

Parametrised RSA datapath: pulls key, modulus and plaintext bytes from the UART receive FIFO, computes text^key mod modulus with a bit-serial modular multiplier, and pushes the result byte-wise into the UART transmit FIFO. It is the next-generation replacement for the fixed 32-bit load/encrypt/send chain, and sits between the UART FIFOs and the top-level controller. It generalises operand width and adds key reuse across blocks, FIFO backpressure, operand reduction and an invalid-modulus flag.

## Interface
- WORD_W, 32, operand/result width in bits; multiple of 8, >= 16
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle pulse in IDLE begins a block; ignored otherwise
- key_reuse  in  1  sampled with start; 1 = reuse stored key/modulus, load text only
- rx_data  in  8  receive FIFO read data, valid the cycle after rx_rd
- rx_empty  in  1  receive FIFO empty
- rx_rd  out  1  receive FIFO read request; reset 0
- tx_data  out  8  transmit byte; reset 0
- tx_full  in  1  transmit FIFO full
- tx_wr  out  1  transmit FIFO write strobe; reset 0
- busy  out  1  high from start acceptance to done; reset 0
- done  out  1  one-cycle pulse after last tx_wr; reset 0
- err_mod  out  1  modulus was 0 in current block; held until next start; reset 0
- key_valid  out  1  stored key/modulus usable for reuse; reset 0

## Operation
- NB = WORD_W/8 bytes per operand, MSB byte first.
- States: IDLE, LD_KEY, LD_MOD, LD_TXT, CHECK, REDUCE, SQR, MUL, SEND, FIN.
- IDLE: on start: clear err_mod, busy=1; key_reuse=1 and key_valid=1 -> LD_TXT, else LD_KEY (key_valid cleared).
- Load states: rx_rd pulsed only when !rx_empty and no read outstanding; byte captured the next cycle and shifted into operand LSB; after NB bytes advance LD_KEY->LD_MOD->LD_TXT->CHECK. Stalls indefinitely on empty.
- LD_MOD completion sets key_valid=1.
- CHECK: modulus==0 -> err_mod=1, result=0, go SEND. Else acc = (modulus==1 ? 0 : 1), bit index = WORD_W-1, go REDUCE.
- REDUCE: base = modmul(text, 1) (handles text >= modulus), then SQR.
- SQR: acc = modmul(acc, acc); key bit set -> MUL, else next bit. MUL: acc = modmul(acc, base), next bit. After bit 0 -> SEND. All WORD_W key bits processed (no leading-zero skip; constant timing per key).
- modmul (Blakley interleaved): P=0; for each bit of a, MSB first: P=2P+(a_i?b:0); subtract m up to twice so P<m. Internal width WORD_W+2; operand b < m guaranteed.
- SEND: one byte per cycle while !tx_full, MSB first; tx_wr only when !tx_full. After NB writes -> FIN.
- FIN: done=1 one cycle, busy=0, -> IDLE.
- Key 0 yields 1 mod m.

## Timing
- Read: 2 cycles per byte minimum; operand load >= 2*NB cycles.
- modmul: start to done exactly WORD_W+1 cycles (1 load + WORD_W iterations).
- Exponentiation: CHECK 1 cycle, REDUCE (WORD_W+1), then per key bit (WORD_W+1) plus (WORD_W+1) if bit set.
- SEND: NB cycles without backpressure; first tx_wr the cycle after entering SEND.
- done one cycle after final tx_wr; start accepted again the following cycle.
- reset asserted anywhere: outputs to reset values immediately, partial operands and key_valid discarded, no further rx_rd/tx_wr; a byte outstanding from an earlier rx_rd is lost.
- start while busy: ignored. tx_full rising in same cycle as intended write: write suppressed, byte held.

## Structure
- Package rsa_pkg: state encoding constants, NB derivation, byte-counter width ($clog2(NB+1)).
- Sub-module mod_mul_serial #(WORD_W): a, b, m, start, done, p; owns the Blakley loop and counter.
- Top holds FSM, operand shift registers, bit index, send shifter.

## Test plan
- WORD_W=32, key=17, mod=3233, text=65, key_reuse=0 -> tx bytes 00 00 0A E6 (2790), err_mod=0, key_valid=1, done once.
- Follow with start, key_reuse=1, text=3298 -> exactly 4 rx_rd, result 00 00 0A E6 (reduction verified).
- key=0, mod=3233, text=123 -> 00 00 00 01; key=5, mod=1 -> 00 00 00 00.
- mod=0 -> err_mod=1, tx 00 00 00 00, done pulse, no modmul activity.
- tx_full toggling every other cycle and rx_empty gaps during load -> same 2790 bytes, no tx_wr while tx_full, no rx_rd while rx_empty.
- reset pulsed mid-SQR, then key_reuse=1 start -> key_valid=0 forces full 12-byte load; WORD_W=64 rerun of first case -> 00 00 00 00 00 00 0A E6.
